// File: rtl/usb_rx_elastic_ctrl.sv
// Read-side sequencer for the receive elastic FIFO: fill hold-off, SKP delete/insert
// drift compensation and RxStatus generation. Optional counters under USB_ELBUF_STATS_EN.
module usb_rx_elastic_ctrl #(
    parameter int ASIZE    = 8,
    parameter int FILL_LVL = 128,
    parameter int HI_LVL   = 160,
    parameter int LO_LVL   = 96
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [ASIZE:0]   fifo_level,
    input  logic             fifo_empty,
    input  logic             fifo_full,
    input  logic [9:0]       fifo_rdata,
    output logic             fifo_rinc,
    output logic [9:0]       out_data,
    output logic             out_valid,
    output logic [2:0]       rx_status,
    output logic             running
`ifdef USB_ELBUF_STATS_EN
    ,
    output logic [15:0]      skp_add_cnt,
    output logic [15:0]      skp_del_cnt,
    output logic [7:0]       ovf_cnt,
    output logic [7:0]       unf_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [ASIZE:0] FILL_LVL_C = FILL_LVL[ASIZE:0];
    localparam logic [ASIZE:0] HI_LVL_C   = HI_LVL[ASIZE:0];
    localparam logic [ASIZE:0] LO_LVL_C   = LO_LVL[ASIZE:0];

    localparam logic [2:0] ST_OK   = 3'b000;
    localparam logic [2:0] ST_ADD  = 3'b001;
    localparam logic [2:0] ST_DEL  = 3'b010;
    localparam logic [2:0] ST_OVF  = 3'b101;
    localparam logic [2:0] ST_UNF  = 3'b110;

    // K28.1 in either running disparity
    function automatic logic is_skp(input logic [9:0] sym);
        return (sym == 10'b0011111001) || (sym == 10'b1100000110);
    endfunction

    state_t      state_q, state_d;
    logic [9:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic [2:0]  status_q, status_d;
    logic        lock_q, lock_d;
    logic        rinc_s;
    logic        ins_s, del_s, ovf_s, unf_s;
    logic        skp_s;

    assign skp_s = is_skp(fifo_rdata);

    // Next-state, read strobe and output decode; enable low overrides everything
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        status_d = ST_OK;
        lock_d   = lock_q;
        rinc_s   = 1'b0;
        ins_s    = 1'b0;
        del_s    = 1'b0;
        ovf_s    = 1'b0;
        unf_s    = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
            lock_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_FILL;
                    lock_d  = 1'b0;
                end
                ST_FILL: begin
                    lock_d = 1'b0;
                    if (fifo_full) begin
                        status_d = ST_OVF;
                        ovf_s    = 1'b1;
                    end else if (fifo_level >= FILL_LVL_C) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
                ST_RUN: begin
                    if (fifo_empty) begin
                        status_d = ST_UNF;
                        state_d  = ST_FILL;
                        unf_s    = 1'b1;
                    end else if (fifo_full) begin
                        rinc_s   = 1'b1;
                        data_d   = fifo_rdata;
                        valid_d  = 1'b1;
                        status_d = ST_OVF;
                        ovf_s    = 1'b1;
                    end else if (skp_s && (fifo_level > HI_LVL_C) && !lock_q) begin
                        rinc_s   = 1'b1;
                        status_d = ST_DEL;
                        lock_d   = 1'b1;
                        del_s    = 1'b1;
                    end else if (skp_s && (fifo_level < LO_LVL_C) && !lock_q) begin
                        // Head is not popped, so the same SKP is forwarded again next cycle
                        data_d   = fifo_rdata;
                        valid_d  = 1'b1;
                        status_d = ST_ADD;
                        lock_d   = 1'b1;
                        ins_s    = 1'b1;
                    end else begin
                        rinc_s   = 1'b1;
                        data_d   = fifo_rdata;
                        valid_d  = 1'b1;
                        lock_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    lock_d  = 1'b0;
                end
            endcase
        end
    end

    // State and registered output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            data_q   <= 10'd0;
            valid_q  <= 1'b0;
            status_q <= 3'b000;
            lock_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            status_q <= status_d;
            lock_q   <= lock_d;
        end
    end

    assign fifo_rinc = rinc_s;
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign rx_status = status_q;
    assign running   = (state_q == ST_RUN);

`ifdef USB_ELBUF_STATS_EN
    logic [15:0] add_cnt_q, del_cnt_q;
    logic [7:0]  ovf_cnt_q, unf_cnt_q;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Saturating event counters, cleared while the receiver is disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_cnt_q <= 16'd0;
            del_cnt_q <= 16'd0;
            ovf_cnt_q <= 8'd0;
            unf_cnt_q <= 8'd0;
        end else if (!enable) begin
            add_cnt_q <= 16'd0;
            del_cnt_q <= 16'd0;
            ovf_cnt_q <= 8'd0;
            unf_cnt_q <= 8'd0;
        end else begin
            if (ins_s) add_cnt_q <= sat_inc16(add_cnt_q);
            if (del_s) del_cnt_q <= sat_inc16(del_cnt_q);
            if (ovf_s) ovf_cnt_q <= sat_inc8(ovf_cnt_q);
            if (unf_s) unf_cnt_q <= sat_inc8(unf_cnt_q);
        end
    end

    assign skp_add_cnt = add_cnt_q;
    assign skp_del_cnt = del_cnt_q;
    assign ovf_cnt     = ovf_cnt_q;
    assign unf_cnt     = unf_cnt_q;
`endif

endmodule
